// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add sequential multiplier, one multiplier bit per cycle, signed or unsigned per request.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iStart,
  input  logic                 iSigned,
  input  logic [WIDTH-1:0]     iA,
  input  logic [WIDTH-1:0]     iB,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2*WIDTH-1:0]   oProduct
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t             state;
  logic [WIDTH-1:0]   mcand, mplier, mag_a, mag_b;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH:0]     sum;
  logic               neg;
  logic [CW-1:0]      cnt;
  always_comb begin
    mag_a    = (iSigned & iA[WIDTH-1]) ? -iA : iA;
    mag_b    = (iSigned & iB[WIDTH-1]) ? -iB : iB;
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mplier[0] ? mcand : '0};
    acc_next = {sum, acc[WIDTH-1:1]};
  end
  // The adder carry becomes the new accumulator MSB as the pair shifts right.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      cnt      <= '0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oProduct <= '0;
    end else begin
      oDone <= 1'b0;
      if (state == IDLE) begin
        if (iStart) begin
          mcand  <= mag_a;
          mplier <= mag_b;
          neg    <= iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
          acc    <= '0;
          cnt    <= CW'(WIDTH);
          oBusy  <= 1'b1;
          state  <= RUN;
        end
      end else begin
        acc    <= acc_next;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          oProduct <= neg ? -acc_next : acc_next;
          oDone    <= 1'b1;
          oBusy    <= 1'b0;
          state    <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: table-driven and randomized checks of seq_multiplier against an arithmetic model.
module tb_seq_multiplier;
  localparam int W = 16;
  logic          Clock = 1'b0, Reset = 1'b1, iStart = 1'b0, iSigned = 1'b0;
  logic [W-1:0]  iA = '0, iB = '0;
  logic          oBusy, oDone;
  logic [2*W-1:0] oProduct;
  int n_pass = 0, n_total = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iSigned(iSigned),
    .iA(iA), .iB(iB), .oBusy(oBusy), .oDone(oDone), .oProduct(oProduct)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic         s;
    logic [W-1:0] a, b;
    logic [2*W-1:0] exp;
    string        nm;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint va, vb, p;
    va = s ? longint'($signed(a)) : longint'(a);
    vb = s ? longint'($signed(b)) : longint'(b);
    p  = va * vb;
    return p[2*W-1:0];
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    while (!oDone && n < 40) begin
      @(posedge Clock); #1; n++;
    end
  endtask

  // Full operation: start, latency, result, busy/done shape.
  task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp, input string nm);
    int n;
    @(negedge Clock);
    iStart = 1'b1; iSigned = s; iA = a; iB = b;
    @(posedge Clock); #1;
    iStart = 1'b0; iA = W'($urandom); iB = W'($urandom); iSigned = 1'($urandom);
    chk({nm, "_busy"}, 64'(oBusy), 64'd1);
    wait_done(n);
    chk({nm, "_lat"}, 64'(n), 64'(W));
    chk({nm, "_prod"}, 64'(oProduct), 64'(exp));
    chk({nm, "_busy0"}, 64'(oBusy), 64'd0);
    @(posedge Clock); #1;
    chk({nm, "_done1cyc"}, 64'(oDone), 64'd0);
  endtask

  initial begin
    vec_t vt[$];
    int n;
    bit seen;
    #12;
    chk("rst_prod", 64'(oProduct), 64'd0);
    chk("rst_done", 64'(oDone), 64'd0);
    chk("rst_busy", 64'(oBusy), 64'd0);
    @(negedge Clock); Reset = 1'b0;

    vt.push_back('{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "umax"});
    vt.push_back('{1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB, "smix"});
    vt.push_back('{1'b1, 16'h8000, 16'h8000, 32'h40000000, "sminmin"});
    vt.push_back('{1'b1, 16'hFFFF, 16'h0000, 32'h00000000, "szero"});
    vt.push_back('{1'b0, 16'h8000, 16'h8000, 32'h40000000, "uhalf"});
    vt.push_back('{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000, "smaxmin"});
    vt.push_back('{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, "snegneg"});
    foreach (vt[i]) do_op(vt[i].s, vt[i].a, vt[i].b, vt[i].exp, vt[i].nm);

    for (int i = 0; i < 40; i++) begin
      logic s; logic [W-1:0] a, b;
      s = 1'($urandom); a = W'($urandom); b = W'($urandom);
      if (i % 8 == 0) a = {1'b1, {(W-1){1'b0}}};
      do_op(s, a, b, ref_mul(s, a, b), $sformatf("rnd%0d", i));
    end

    // Start during RUN is ignored; start in the done cycle is accepted.
    @(negedge Clock);
    iStart = 1'b1; iSigned = 1'b0; iA = 16'd10; iB = 16'd10;
    @(posedge Clock); #1; iStart = 1'b0;
    repeat (4) @(posedge Clock);
    #1; iStart = 1'b1; iA = 16'd2; iB = 16'd3;
    @(posedge Clock); #1; iStart = 1'b0;
    wait_done(n);
    chk("hs_lat", 64'(n), 64'(W - 5));
    chk("hs_ignored", 64'(oProduct), 64'd100);
    iStart = 1'b1; iA = 16'd2; iB = 16'd3;
    @(posedge Clock); #1; iStart = 1'b0;
    chk("hs_b2b_busy", 64'(oBusy), 64'd1);
    wait_done(n);
    chk("hs_b2b_lat", 64'(n), 64'(W));
    chk("hs_b2b_prod", 64'(oProduct), 64'd6);

    // Async reset mid-cycle clears outputs before the next edge.
    @(negedge Clock);
    iStart = 1'b1; iA = 16'd1234; iB = 16'd5678;
    @(posedge Clock); #1; iStart = 1'b0;
    repeat (7) @(posedge Clock);
    #3; Reset = 1'b1; #1;
    chk("async_prod", 64'(oProduct), 64'd0);
    chk("async_busy", 64'(oBusy), 64'd0);
    chk("async_done", 64'(oDone), 64'd0);
    @(negedge Clock); Reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge Clock); #1;
      if (oDone) seen = 1'b1;
    end
    chk("abort_nodone", 64'(seen), 64'd0);
    chk("abort_prod", 64'(oProduct), 64'd0);
    do_op(1'b0, 16'd3, 16'd4, 32'd12, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier that serves as the multiply execution unit behind the MiniAlu `SMUL`/`UMUL` opcodes. It replaces a fully combinational array multiplier with a one-bit-per-cycle datapath. The datapath supports signed or unsigned operation per request and uses a start/done handshake. The ALU control stalls on `oBusy` and writes `oProduct` to data RAM when `oDone` pulses.

## Interface
- `WIDTH`, default 16: operand width in bits, ≥2; product width is 2·WIDTH.
- `Clock`  in  1  system clock, all state on rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state immediately.
- `iStart`  in  1  request strobe; sampled only in IDLE.
- `iSigned`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `iStart`.
- `iA`  in  WIDTH  multiplicand; sampled with `iStart`.
- `iB`  in  WIDTH  multiplier; sampled with `iStart`.
- `oBusy`  out  1  high while an operation is in progress (RUN state).
- `oDone`  out  1  single-cycle pulse: `oProduct` has just been updated.
- `oProduct`  out  2·WIDTH  result register; holds until the next completion.

## Operation
- FSM with 2 states, IDLE and RUN. Reset state is IDLE.
- **IDLE, `iStart`=1 at an edge:**
  - Latch `|iA|` and `|iB|` into the internal magnitude registers. Magnitudes are taken only when `iSigned`=1 and the MSB is set; otherwise the raw value is latched.
  - Latch result sign = `iSigned & (iA[MSB] ^ iB[MSB])`.
  - Clear the accumulator, load bit counter = WIDTH, go to RUN.
- Magnitude of the most-negative value −2^(WIDTH−1) is 2^(WIDTH−1). It fits the unsigned WIDTH-bit magnitude register, so no special case is needed.
- **RUN, each edge:**
  - If multiplier LSB = 1, add multiplicand magnitude into accumulator bits [2·WIDTH−1:WIDTH]; the carry is kept.
  - Shift the {carry, accumulator} right by 1 and shift the multiplier magnitude right by 1.
  - Decrement the counter.
- **RUN, edge where counter goes 1→0:**
  - Register the final accumulator into `oProduct`, two's-complement-negated over 2·WIDTH bits if the latched sign = 1.
  - Assert `oDone` for the following cycle and return to IDLE.
- Negating a zero product yields zero. `oProduct` is never −0 and has no sign artefact.
- `iStart` while in RUN is ignored. There is no queueing, and inputs may change freely during RUN.
- `iStart` in the cycle where `oDone` is high is accepted, because the FSM is already IDLE. Back-to-back operations therefore sustain a throughput of one operation per WIDTH+1 cycles.
- **Reset asserted (any time, including mid-RUN):**
  - `oProduct`=0, `oDone`=0, `oBusy`=0, state IDLE, counter 0.
  - The partial result is discarded.
- Unsigned mode: `oProduct` = iA·iB exactly, no overflow.
- Signed mode: `oProduct` = iA·iB as a 2·WIDTH two's-complement value, exactly.

## Timing
- Start accepted at edge k, so `oBusy` = 1 in the cycles after edges k … k+WIDTH−1.
- `oProduct` updates at edge k+WIDTH. `oDone` = 1 between edges k+WIDTH and k+WIDTH+1, and `oBusy` = 0 in that cycle.
- Latency from the accepting edge to the result is WIDTH cycles; for WIDTH=16 that is 16 cycles.
- `oDone` is exactly one cycle wide and never asserted without a preceding accepted start.
- All outputs are registered. There is no combinational path from inputs to outputs.
- The critical path is one WIDTH-bit adder plus the shift mux. The final negation adds one 2·WIDTH-bit incrementer on the last cycle only.

## Test plan
- **Reset:** Reset=1 async mid-cycle → `oProduct`=0, `oDone`=0, `oBusy`=0 immediately, before the next clock edge.
- **Unsigned max:** WIDTH=16, `iSigned`=0, iA=16'hFFFF, iB=16'hFFFF → after 16 cycles `oProduct`=32'hFFFE0001, `oDone` high for exactly 1 cycle.
- **Signed mixed:** `iSigned`=1, iA=16'hFFFD (−3), iB=16'h0007 → `oProduct`=32'hFFFFFFEB (−21). Repeat with iA=16'h8000, iB=16'h8000 → `oProduct`=32'h40000000.
- **Zero with sign:** `iSigned`=1, iA=16'hFFFF (−1), iB=0 → `oProduct`=0.
- **Handshake:**
  - Second `iStart` (iA=2, iB=3) pulsed 5 cycles into RUN of 10×10 → ignored; `oProduct`=100.
  - Then `iStart` with iA=2, iB=3 in the `oDone` cycle → accepted; `oProduct`=6 exactly 16 cycles later.
- **Reset mid-operation:** start 1234×5678, assert Reset at cycle 8, release, start 3×4 → no `oDone` for the aborted operation; `oProduct`=12 after 16 cycles.
